// File: rtl/class_chunk_accum.sv
// Class-HV chunk accumulator: for each chunk, read a class-memory row, add the chunk bits into
// the saturating per-dimension counters, and write the row back. `define CLASS_ACC_BIPOLAR_EN for signed +1/-1 counters.
module class_chunk_accum #(
    parameter int HV_DIM      = 5000,
    parameter int DIMS_PER_CC = 500,
    parameter int NUM_CHUNKS  = HV_DIM / DIMS_PER_CC,
    parameter int NUM_CLASSES = 26,
    parameter int CTR_W       = 8,
    parameter int ADDR_W      = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [4:0]                   class_idx,
    input  logic                         training_hdc_model,
    input  logic [DIMS_PER_CC-1:0]       input_hv_chunk,
    output logic [3:0]                   nonbin_ctr,
    output logic                         mem_rd_en,
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [DIMS_PER_CC*CTR_W-1:0] mem_rd_data,
    output logic [DIMS_PER_CC*CTR_W-1:0] mem_wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int ROW_W = DIMS_PER_CC * CTR_W;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_WR, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [3:0]          ctr_q, ctr_d;
    logic [4:0]          cls_q, cls_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ROW_W-1:0]    wr_data_q, wr_data_d;
    logic                err_q, err_d;
    logic [ROW_W-1:0]    acc_row;

    function automatic logic [ADDR_W-1:0] row_addr(input logic [4:0] c, input logic [3:0] k);
        return ADDR_W'(c) * ADDR_W'(NUM_CHUNKS) + ADDR_W'(k);
    endfunction

    // Per-lane saturating update of the row read back from memory.
    always_comb begin
        logic [CTR_W-1:0] old_v;
        logic [CTR_W-1:0] new_v;
        acc_row = '0;
        old_v   = '0;
        new_v   = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            old_v = mem_rd_data[i*CTR_W +: CTR_W];
`ifdef CLASS_ACC_BIPOLAR_EN
            if (input_hv_chunk[i])
                new_v = (old_v == {1'b0, {(CTR_W-1){1'b1}}}) ? old_v : old_v + CTR_W'(1);
            else
                new_v = (old_v == {1'b1, {(CTR_W-1){1'b0}}}) ? old_v : old_v - CTR_W'(1);
`else
            new_v = (input_hv_chunk[i] && old_v != {CTR_W{1'b1}}) ? old_v + CTR_W'(1) : old_v;
`endif
            acc_row[i*CTR_W +: CTR_W] = new_v;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        cls_d     = cls_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && training_hdc_model) begin
                    cls_d = class_idx;
                    ctr_d = '0;
                    if (32'(class_idx) >= NUM_CLASSES) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = row_addr(class_idx, 4'd0);
                        state_d = S_RD;
                    end
                end
            end
            S_RD:  state_d = S_ACC;
            S_ACC: begin
                wr_data_d = acc_row;
                state_d   = S_WR;
            end
            S_WR: begin
                if (ctr_q == 4'(NUM_CHUNKS - 1)) begin
                    state_d = S_FIN;
                end else begin
                    ctr_d   = ctr_q + 4'd1;
                    addr_d  = row_addr(cls_q, ctr_q + 4'd1);
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                ctr_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctr_q     <= '0;
            cls_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            cls_q     <= cls_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign nonbin_ctr  = ctr_q;
    assign mem_rd_en   = (state_q == S_RD);
    assign mem_wr_en   = (state_q == S_WR);
    assign mem_addr    = addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign err         = (state_q == S_FIN) && err_q;
endmodule

// File: tb/tb_class_chunk_accum.sv
// Directed bench for class_chunk_accum with a behavioural 1-cycle-latency class memory.
module tb_class_chunk_accum;
    localparam int DIMS  = 500;
    localparam int CTR_W = 8;
    localparam int ROW_W = DIMS * CTR_W;
    localparam int ROWS  = 260;

    logic             clk = 1'b0;
    logic             rst_n, start, training_hdc_model;
    logic [4:0]       class_idx;
    logic [DIMS-1:0]  pat, input_hv_chunk;
    logic [3:0]       nonbin_ctr;
    logic             mem_rd_en, mem_wr_en, busy, done, err;
    logic [8:0]       mem_addr;
    logic [ROW_W-1:0] rd_data, mem_wr_data;

    logic [ROW_W-1:0] mem [0:ROWS-1];
    logic [8:0]       wr_log [0:2047];
    int               wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic             clr_req = 1'b0, pl_en = 1'b0;
    int               pl_addr = 0;
    logic [ROW_W-1:0] pl_data = '0;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign input_hv_chunk = training_hdc_model ? pat : '0;

    class_chunk_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .class_idx(class_idx),
        .training_hdc_model(training_hdc_model), .input_hv_chunk(input_hv_chunk),
        .nonbin_ctr(nonbin_ctr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_rd_data(rd_data), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (clr_req) for (int r = 0; r < ROWS; r++) mem[r] <= '0;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_rd_en) begin
            rd_data <= (int'(mem_addr) < ROWS) ? mem[mem_addr] : '0;
            rd_cnt  <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            if (int'(mem_addr) < ROWS) mem[mem_addr] <= mem_wr_data;
            wr_log[wr_cnt] <= mem_addr;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic       rd, wr, busy, done, err, chk_ctr, chk_addr;
        logic [3:0] ctr;
        logic [8:0] addr;
    } vec_t;
    vec_t tbl [32];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkrow(input string name, input int a, input logic [ROW_W-1:0] exp);
        checks++;
        if (mem[a] !== exp) begin
            errors++;
            for (int i = 0; i < DIMS; i++)
                if (mem[a][i*CTR_W +: CTR_W] !== exp[i*CTR_W +: CTR_W]) begin
                    $display("FAIL %s: row %0d lane %0d got 0x%0h expected 0x%0h", name, a, i,
                             mem[a][i*CTR_W +: CTR_W], exp[i*CTR_W +: CTR_W]);
                    break;
                end
        end
    endtask

    // Checks that exactly n writes happened since base, to addresses a0, a0+1, ...
    task automatic chklog(input string name, input int base, input int n, input int a0);
        logic ok;
        ok = (wr_cnt - base == n);
        for (int k = 0; k < n && ok; k++) ok = (int'(wr_log[base+k]) == a0 + k);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d writes from addr %0d, expected %0d writes from %0d",
                     name, wr_cnt - base, int'(wr_log[base]), n, a0);
        end
    endtask

    function automatic logic [ROW_W-1:0] fill(input logic [7:0] v);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < DIMS; i++) r[i*CTR_W +: CTR_W] = v;
        return r;
    endfunction

    // Issues a start for class c and returns the cycle (accept = 0) at which done is seen.
    task automatic run(input logic [4:0] c, output int dcyc);
        class_idx = c;
        start = 1'b1;
        step();
        start = 1'b0;
        dcyc = 1;
        while (!done && dcyc < 200) begin
            step();
            dcyc++;
        end
    endtask

    task automatic clear_mem();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    task automatic preload(input int a, input logic [ROW_W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, wb, rb, k, ph;
        logic bad;
        logic [ROW_W-1:0] e;

        for (int c = 1; c <= 32; c++) begin
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            tbl[c-1].rd       = (c <= 30) && (ph == 0);
            tbl[c-1].wr       = (c <= 30) && (ph == 2);
            tbl[c-1].busy     = (c <= 31);
            tbl[c-1].done     = (c == 31);
            tbl[c-1].err      = 1'b0;
            tbl[c-1].chk_ctr  = (c != 31);
            tbl[c-1].ctr      = (c <= 30) ? 4'(k) : 4'd0;
            tbl[c-1].chk_addr = (c <= 30);
            tbl[c-1].addr     = 9'(30 + k);
        end

        rst_n = 1'b0; start = 1'b0; training_hdc_model = 1'b1; class_idx = '0; pat = '0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        chk("rst_ctr", 64'(nonbin_ctr), 0);
        chk("rst_rd", 64'(mem_rd_en), 0);
        chk("rst_wr", 64'(mem_wr_en), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_wdata", 64'(|mem_wr_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        rst_n = 1'b1;
        step();

        // Increment: class 3, all-ones chunks, per-cycle schedule from the table
        pat = '1;
        wb = wr_cnt; rb = rd_cnt;
        class_idx = 5'd3;
        start = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            start = 1'b0;
            chk($sformatf("cyc%0d", c),
                {46'd0, mem_rd_en, mem_wr_en, busy, done, err,
                 tbl[c-1].chk_ctr ? nonbin_ctr : 4'd0, tbl[c-1].chk_addr ? mem_addr : 9'd0},
                {46'd0, tbl[c-1].rd, tbl[c-1].wr, tbl[c-1].busy, tbl[c-1].done, tbl[c-1].err,
                 tbl[c-1].chk_ctr ? tbl[c-1].ctr : 4'd0, tbl[c-1].chk_addr ? tbl[c-1].addr : 9'd0});
        end
        chklog("inc_writes", wb, 10, 30);
        chk("inc_reads", 64'(rd_cnt - rb), 10);
        chkrow("inc_row30", 30, fill(8'd1));
        chkrow("inc_row39", 39, fill(8'd1));
        chkrow("inc_row29", 29, '0);
        chkrow("inc_row40", 40, '0);

        // Back-to-back: start in cycle 32, right after done
        wb = wr_cnt;
        run(5'd25, dcyc);
        chk("b2b_done_cyc", 64'(dcyc), 31);
        chklog("b2b_writes", wb, 10, 250);
        chkrow("b2b_row250", 250, fill(8'd1));
        chkrow("b2b_row259", 259, fill(8'd1));
        chkrow("b2b_row35", 35, fill(8'd1));
        step();

        // Invalid class: done+err at cycle 1, no memory traffic
        wb = wr_cnt; rb = rd_cnt;
        class_idx = 5'd26;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("inv_cyc1", {61'd0, done, err, mem_rd_en}, {61'd0, 1'b1, 1'b1, 1'b0});
        step();
        chk("inv_cyc2", {61'd0, done, err, busy}, 0);
        run(5'd31, dcyc);
        chk("inv31_cyc", {61'd0, 2'(dcyc), err}, {61'd0, 2'd1, 1'b1});
        step();
        chk("inv_traffic", 64'((wr_cnt - wb) + (rd_cnt - rb)), 0);

        // training_hdc_model low: start ignored
        rb = rd_cnt;
        training_hdc_model = 1'b0;
        class_idx = 5'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bad |= busy | done;
            step();
        end
        chk("notrain_idle", 64'(bad), 0);
        chk("notrain_reads", 64'(rd_cnt - rb), 0);
        training_hdc_model = 1'b1;

        // start while busy (cycle 5) and during FIN: both ignored
        wb = wr_cnt;
        class_idx = 5'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i <= 5; i++) step();
        class_idx = 5'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        dcyc = 6;
        while (!done && dcyc < 200) begin step(); dcyc++; end
        chk("ign_done_cyc", 64'(dcyc), 31);
        class_idx = 5'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_fin_start", 64'(busy), 0);
        chklog("ign_writes", wb, 10, 50);

        // Saturation on row 0
        clear_mem();
        e = '0;
`ifdef CLASS_ACC_BIPOLAR_EN
        e[0 +: 8] = 8'h7F; e[8 +: 8] = 8'h80; e[16 +: 8] = 8'd7;
`else
        e[0 +: 8] = 8'hFF; e[8 +: 8] = 8'hFF; e[16 +: 8] = 8'd7;
`endif
        preload(0, e);
        pat = '0; pat[0] = 1'b1; pat[2] = 1'b1;
        run(5'd0, dcyc);
        chk("sat_done_cyc", 64'(dcyc), 31);
`ifdef CLASS_ACC_BIPOLAR_EN
        e = fill(8'hFF); e[0 +: 8] = 8'h7F; e[8 +: 8] = 8'h80; e[16 +: 8] = 8'd8;
        chkrow("sat_row0", 0, e);
        e = fill(8'hFF); e[0 +: 8] = 8'd1; e[16 +: 8] = 8'd1;
        chkrow("sat_row1", 1, e);
`else
        e = '0; e[0 +: 8] = 8'hFF; e[8 +: 8] = 8'hFF; e[16 +: 8] = 8'd8;
        chkrow("sat_row0", 0, e);
        e = '0; e[0 +: 8] = 8'd1; e[16 +: 8] = 8'd1;
        chkrow("sat_row1", 1, e);
`endif
        step();

`ifdef CLASS_ACC_BIPOLAR_EN
        // Alternating bits from zero: lanes go +1/-1
        clear_mem();
        for (int i = 0; i < DIMS; i++) pat[i] = (i % 2 == 0);
        run(5'd1, dcyc);
        for (int i = 0; i < DIMS; i++) e[i*CTR_W +: CTR_W] = (i % 2 == 0) ? 8'h01 : 8'hFF;
        chkrow("bip_row10", 10, e);
        chkrow("bip_row19", 19, e);
        step();
`endif

        // Reset during ACC of chunk 4 (cycle 14)
        pat = '1;
        wb = wr_cnt;
        class_idx = 5'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i <= 14; i++) step();
        chk("rst_acc_state", {59'd0, nonbin_ctr, mem_rd_en, mem_wr_en}, {59'd0, 4'd4, 2'b00});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_outs", {50'd0, nonbin_ctr, mem_rd_en, mem_wr_en, busy, done, err, 4'd0},
            64'(|mem_addr) << 4 | 64'(|mem_wr_data) << 5);
        chklog("rst_mid_writes", wb, 4, 100);
        chkrow("rst_row104", 104, '0);
        wb = wr_cnt;
        run(5'd10, dcyc);
        chk("rst_rerun_cyc", 64'(dcyc), 31);
        chklog("rst_rerun_writes", wb, 10, 100);
        chkrow("rst_row103", 103, fill(8'd2));
        chkrow("rst_row104b", 104, fill(8'd1));
        step();

        chk("rd_wr_overlap", 64'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/class_chunk_accum.md
Name: class_chunk_accum

Overview:
- Training-path stage directly downstream of the class-HV input chunk mux.
- Sequences `nonbin_ctr` through chunks 0..NUM_CHUNKS-1 and consumes each DIMS_PER_CC-bit chunk.
- For each chunk, performs a read-modify-write on the non-binary class-HV memory: every set bit increments that dimension's counter, with saturation.
- One `start` accumulates one encoded HV into one class.

Parameters:
- HV_DIM, 5000, full hypervector width.
- DIMS_PER_CC, 500, dimensions handled per chunk.
- NUM_CHUNKS, 10, HV_DIM/DIMS_PER_CC.
- NUM_CLASSES, 26, number of class hypervectors.
- CTR_W, 8, bits per dimension counter (unsigned).
- ADDR_W, 9, memory address width; must satisfy ADDR_W >= clog2(NUM_CLASSES*NUM_CHUNKS).

Ports:
- clk, in, 1, single clock; all logic is on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- start, in, 1, one-cycle request to accumulate the current chunk stream into class_idx.
- class_idx, in, 5, target class; sampled only on an accepted start.
- training_hdc_model, in, 1, training mode; start is accepted only when this is 1.
- input_hv_chunk, in, DIMS_PER_CC, chunk selected by nonbin_ctr (from the upstream mux).
- nonbin_ctr, out, 4, chunk index driven to the upstream mux.
- mem_rd_en, out, 1, class-memory read strobe.
- mem_wr_en, out, 1, class-memory write strobe.
- mem_addr, out, ADDR_W, row address = class*NUM_CHUNKS + chunk.
- mem_rd_data, in, DIMS_PER_CC*CTR_W, read data; valid exactly 1 cycle after mem_rd_en.
- mem_wr_data, out, DIMS_PER_CC*CTR_W, updated counters.
- busy, out, 1, high from the accept cycle+1 through the DONE state.
- done, out, 1, one-cycle pulse at the end of a sequence.
- err, out, 1, one-cycle pulse, coincident with done, when class_idx >= NUM_CLASSES.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - nonbin_ctr, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, busy, done, err are all 0.
  - Reset mid-sequence aborts immediately. No write is issued after the reset edge; a partially updated class is acceptable.
- FSM states: IDLE, RD, ACC, WR, FIN.
  - IDLE:
    - Accept start only if training_hdc_model=1.
    - On accept, latch class_idx and set nonbin_ctr=0.
    - If latched class_idx >= NUM_CLASSES, go to FIN with err pending; no memory access occurs.
    - Otherwise go to RD.
  - RD:
    - mem_rd_en=1 for exactly one cycle; mem_addr=class*NUM_CHUNKS+nonbin_ctr.
    - Next state ACC.
  - ACC:
    - Capture mem_rd_data.
    - For every bit i, new_ctr[i] = old_ctr[i] + input_hv_chunk[i], saturating at 2^CTR_W-1 (never wraps).
    - Register the result into mem_wr_data. Next state WR.
  - WR:
    - mem_wr_en=1 for one cycle; mem_addr is unchanged from RD.
    - If nonbin_ctr == NUM_CHUNKS-1, go to FIN.
    - Otherwise increment nonbin_ctr and go to RD.
  - FIN:
    - done=1 for one cycle; err=1 if pending.
    - nonbin_ctr returns to 0. Next state IDLE.
- Ordering and data:
  - Counter lane i of mem_rd_data/mem_wr_data occupies bits [i*CTR_W +: CTR_W] and corresponds to chunk bit i.
  - nonbin_ctr is held stable through each RD/ACC/WR triple, so the upstream mux output is stable when sampled in ACC.
  - mem_rd_en and mem_wr_en are never high in the same cycle.
- Latency:
  - Accept at cycle 0; RD at cycle 1; 3 cycles per chunk.
  - Last WR at cycle 3*NUM_CHUNKS; done at cycle 3*NUM_CHUNKS+1 (31 with defaults).
  - busy is high in cycles 1..31.
  - Invalid class: done and err at cycle 1.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - start in the FIN cycle: ignored.
  - start with training_hdc_model=0: ignored; no busy, no done.
  - training_hdc_model falling mid-sequence: the sequence continues. The upstream mux then supplies zeros, so the affected rows are rewritten unchanged.
  - class_idx changing after accept: no effect.

Optional Feature:
- Macro: CLASS_ACC_BIPOLAR_EN.
- Defined:
  - Counters are signed two's complement.
  - A set bit adds +1 and a clear bit adds -1.
  - Saturation bounds are -(2^(CTR_W-1)) and 2^(CTR_W-1)-1.
- Not defined:
  - Counters are unsigned.
  - A clear bit adds 0.
  - Saturation applies at 2^CTR_W-1 only.

Test Plan:
- Increment, defaults, memory all zero:
  - Stimulus: class_idx=3, chunk=all ones for every nonbin_ctr, single start.
  - Response: 10 writes to addresses 30..39, each with every lane =1; done at cycle 31; busy high in cycles 1..31; no other addresses touched.
- Saturation:
  - Stimulus: preload row 0 lanes to 255; chunk bit 0 set; start with class 0.
  - Response: row 0 lane 0 stays 255 (no wrap); other lanes unchanged.
- Invalid class and ignored starts:
  - class_idx=26 -> done=err=1 at cycle 1, no mem_rd_en or mem_wr_en.
  - start with training_hdc_model=0 -> no activity.
  - start pulsed at cycle 5 of an active sequence -> ignored; exactly 10 writes total.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during the ACC state of chunk 4.
  - Response: next cycle all outputs are 0 and state is IDLE; no WR for chunk 4; a new start then completes normally.
- Back-to-back:
  - Stimulus: start at cycle 32 (the cycle after done) with class 25, memory preloaded from the first run.
  - Response: accepted; mem_addr runs 250..259; lanes incremented by one.
- Bipolar mode (CLASS_ACC_BIPOLAR_EN):
  - Stimulus: chunk pattern alternating 1/0, memory zero.
  - Response: lanes alternate +1/-1 (0x01/0xFF); a lane preloaded to -128 with input 0 stays at -128.
